// File: rtl/decode_control_pipe.sv
// Decode control for the pipelined MIPS core: combinational decode of the
// instruction in ID, registered into the ID/EX boundary with stall/flush/bubble
// handling, a HI/LO busy counter and a syscall handshake FSM.
module decode_control_pipe #(
    parameter int ALU_OP_W = 4,
    parameter int BV_W     = 3,
    parameter int MUL_LAT  = 4,
    parameter int DIV_LAT  = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic [4:0]          reg_rt_id,
    input  logic                id_valid,
    input  logic                ex_stall,
    input  logic                flush,
    input  logic                syscall_done,
    output logic                id_stall,
    output logic                muldiv_busy,
    output logic                syscall_pending,
    output logic                ex_valid,
    output logic                ex_reg_write,
    output logic                ex_mem_to_reg,
    output logic                ex_mem_write,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic                ex_alu_src,
    output logic                ex_reg_dest,
    output logic [BV_W-1:0]     ex_branch_variant,
    output logic [1:0]          ex_muldiv_op,
    output logic [1:0]          ex_hilo_rd
);

    localparam int CNT_W = $clog2(DIV_LAT + 1);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SW      = 6'h2b;

    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0c;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1a;
    localparam logic [5:0] FN_DIVU    = 6'h1b;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLT     = 6'h2a;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] ALU_XOR = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] ALU_NOR = ALU_OP_W'(5);
    localparam logic [ALU_OP_W-1:0] ALU_SLT = ALU_OP_W'(6);
    localparam logic [ALU_OP_W-1:0] ALU_SLL = ALU_OP_W'(7);
    localparam logic [ALU_OP_W-1:0] ALU_SRA = ALU_OP_W'(8);
    localparam logic [ALU_OP_W-1:0] ALU_LUI = ALU_OP_W'(9);

    localparam logic [BV_W-1:0] BV_NONE      = BV_W'(0);
    localparam logic [BV_W-1:0] BV_BEQ       = BV_W'(1);
    localparam logic [BV_W-1:0] BV_BNE       = BV_W'(2);
    localparam logic [BV_W-1:0] BV_BLTZ      = BV_W'(3);
    localparam logic [BV_W-1:0] BV_JUMP      = BV_W'(4);
    localparam logic [BV_W-1:0] BV_JUMP_LINK = BV_W'(5);
    localparam logic [BV_W-1:0] BV_JUMP_REG  = BV_W'(6);

    typedef enum logic {
        SC_IDLE,
        SC_WAIT
    } sc_state_t;

    sc_state_t          sc_state;
    sc_state_t          sc_next;
    logic [CNT_W-1:0]   muldiv_cnt;

    logic                dec_reg_write;
    logic                dec_mem_to_reg;
    logic                dec_mem_write;
    logic [ALU_OP_W-1:0] dec_alu_op;
    logic                dec_alu_src;
    logic                dec_reg_dest;
    logic [BV_W-1:0]     dec_branch_variant;
    logic [1:0]          dec_muldiv_op;
    logic [1:0]          dec_hilo_rd;
    logic                dec_syscall;
    logic                hilo_user;
    logic                accept;

    // Combinational decode of the instruction currently held in ID
    always_comb begin
        dec_reg_write      = 1'b0;
        dec_mem_to_reg     = 1'b0;
        dec_mem_write      = 1'b0;
        dec_alu_op         = ALU_ADD;
        dec_alu_src        = 1'b0;
        dec_reg_dest       = 1'b0;
        dec_branch_variant = BV_NONE;
        dec_muldiv_op      = 2'b00;
        dec_hilo_rd        = 2'b00;
        dec_syscall        = 1'b0;
        case (opcode)
            OP_SPECIAL: begin
                dec_reg_dest  = 1'b1;
                dec_reg_write = 1'b1;
                case (funct)
                    FN_SLL:     begin dec_alu_op = ALU_SLL; dec_alu_src = 1'b1; end
                    FN_SRA:     begin dec_alu_op = ALU_SRA; dec_alu_src = 1'b1; end
                    FN_JR:      begin dec_reg_write = 1'b0; dec_branch_variant = BV_JUMP_REG; end
                    FN_SYSCALL: begin dec_reg_write = 1'b0; dec_syscall = 1'b1; end
                    FN_MULT,
                    FN_MULTU:   begin dec_reg_write = 1'b0; dec_muldiv_op = 2'b01; end
                    FN_DIV,
                    FN_DIVU:    begin dec_reg_write = 1'b0; dec_muldiv_op = 2'b10; end
                    FN_MFHI:    dec_hilo_rd = 2'b10;
                    FN_MFLO:    dec_hilo_rd = 2'b01;
                    FN_ADDU:    dec_alu_op = ALU_ADD;
                    FN_SUBU:    dec_alu_op = ALU_SUB;
                    FN_AND:     dec_alu_op = ALU_AND;
                    FN_OR:      dec_alu_op = ALU_OR;
                    FN_XOR:     dec_alu_op = ALU_XOR;
                    FN_NOR:     dec_alu_op = ALU_NOR;
                    FN_SLT:     dec_alu_op = ALU_SLT;
                    default:    dec_alu_op = ALU_ADD;
                endcase
            end
            OP_REGIMM: begin
                dec_alu_op = ALU_SUB;
                if (reg_rt_id == 5'd0) begin
                    dec_branch_variant = BV_BLTZ;
                end
            end
            OP_J:      dec_branch_variant = BV_JUMP;
            OP_JAL:    dec_branch_variant = BV_JUMP_LINK;
            OP_BEQ:    begin dec_branch_variant = BV_BEQ; dec_alu_op = ALU_SUB; end
            OP_BNE:    begin dec_branch_variant = BV_BNE; dec_alu_op = ALU_SUB; end
            OP_ADDIU:  begin dec_reg_write = 1'b1; dec_alu_src = 1'b1; dec_alu_op = ALU_ADD; end
            OP_ORI:    begin dec_reg_write = 1'b1; dec_alu_src = 1'b1; dec_alu_op = ALU_OR; end
            OP_LUI:    begin dec_reg_write = 1'b1; dec_alu_src = 1'b1; dec_alu_op = ALU_LUI; end
            OP_LW:     begin dec_reg_write = 1'b1; dec_mem_to_reg = 1'b1; dec_alu_src = 1'b1; end
            OP_SW,
            OP_SB:     begin dec_mem_write = 1'b1; dec_alu_src = 1'b1; end
            default:   dec_alu_op = ALU_ADD;
        endcase
    end

    assign hilo_user       = (dec_muldiv_op != 2'b00) || (dec_hilo_rd != 2'b00);
    assign muldiv_busy     = (muldiv_cnt != '0);
    assign syscall_pending = (sc_state == SC_WAIT);
    assign id_stall        = id_valid && ((muldiv_busy && hilo_user) || syscall_pending);
    assign accept          = id_valid && !flush && !id_stall && !ex_stall;

    // ID/EX register: reset, then hold on ex_stall, then bubble, else accept
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid          <= 1'b0;
            ex_reg_write      <= 1'b0;
            ex_mem_to_reg     <= 1'b0;
            ex_mem_write      <= 1'b0;
            ex_alu_op         <= '0;
            ex_alu_src        <= 1'b0;
            ex_reg_dest       <= 1'b0;
            ex_branch_variant <= BV_NONE;
            ex_muldiv_op      <= 2'b00;
            ex_hilo_rd        <= 2'b00;
        end else if (ex_stall) begin
            ex_valid          <= ex_valid;
        end else if (!accept) begin
            ex_valid          <= 1'b0;
            ex_reg_write      <= 1'b0;
            ex_mem_to_reg     <= 1'b0;
            ex_mem_write      <= 1'b0;
            ex_alu_op         <= '0;
            ex_alu_src        <= 1'b0;
            ex_reg_dest       <= 1'b0;
            ex_branch_variant <= BV_NONE;
            ex_muldiv_op      <= 2'b00;
            ex_hilo_rd        <= 2'b00;
        end else begin
            ex_valid          <= 1'b1;
            ex_reg_write      <= dec_reg_write;
            ex_mem_to_reg     <= dec_mem_to_reg;
            ex_mem_write      <= dec_mem_write;
            ex_alu_op         <= dec_alu_op;
            ex_alu_src        <= dec_alu_src;
            ex_reg_dest       <= dec_reg_dest;
            ex_branch_variant <= dec_branch_variant;
            ex_muldiv_op      <= dec_muldiv_op;
            ex_hilo_rd        <= dec_hilo_rd;
        end
    end

    // HI/LO busy counter: loads on an accepted mul/div, otherwise counts down to zero
    always_ff @(posedge clk) begin
        if (reset) begin
            muldiv_cnt <= '0;
        end else if (accept && dec_muldiv_op == 2'b01) begin
            muldiv_cnt <= CNT_W'(MUL_LAT);
        end else if (accept && dec_muldiv_op == 2'b10) begin
            muldiv_cnt <= CNT_W'(DIV_LAT);
        end else if (muldiv_cnt != '0) begin
            muldiv_cnt <= muldiv_cnt - CNT_W'(1);
        end
    end

    // Syscall handshake state register
    always_ff @(posedge clk) begin
        if (reset) begin
            sc_state <= SC_IDLE;
        end else begin
            sc_state <= sc_next;
        end
    end

    // Syscall next state: enter WAIT on an accepted SYSCALL, leave on host ack
    always_comb begin
        sc_next = sc_state;
        case (sc_state)
            SC_IDLE: if (accept && dec_syscall) sc_next = SC_WAIT;
            SC_WAIT: if (syscall_done)          sc_next = SC_IDLE;
            default: sc_next = SC_IDLE;
        endcase
    end

endmodule

// File: tb/tb_decode_control_pipe.sv
// Directed self-checking bench for decode_control_pipe.
module tb_decode_control_pipe;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] reg_rt_id;
    logic       id_valid;
    logic       ex_stall;
    logic       flush;
    logic       syscall_done;
    logic       id_stall;
    logic       muldiv_busy;
    logic       syscall_pending;
    logic       ex_valid;
    logic       ex_reg_write;
    logic       ex_mem_to_reg;
    logic       ex_mem_write;
    logic [3:0] ex_alu_op;
    logic       ex_alu_src;
    logic       ex_reg_dest;
    logic [2:0] ex_branch_variant;
    logic [1:0] ex_muldiv_op;
    logic [1:0] ex_hilo_rd;

    localparam logic [2:0] BV_NONE     = 3'd0;
    localparam logic [2:0] BV_BEQ      = 3'd1;
    localparam logic [2:0] BV_BNE      = 3'd2;
    localparam logic [2:0] BV_BLTZ     = 3'd3;
    localparam logic [2:0] BV_JUMP     = 3'd4;
    localparam logic [2:0] BV_JUMP_REG = 3'd6;
    localparam logic [3:0] ALU_ADD     = 4'd0;
    localparam logic [3:0] ALU_SUB     = 4'd1;
    localparam logic [3:0] ALU_OR      = 4'd3;

    int checks = 0;
    int passes = 0;
    int stall_cycles;

    decode_control_pipe #(
        .ALU_OP_W(4), .BV_W(3), .MUL_LAT(4), .DIV_LAT(32)
    ) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .reg_rt_id(reg_rt_id), .id_valid(id_valid), .ex_stall(ex_stall),
        .flush(flush), .syscall_done(syscall_done), .id_stall(id_stall),
        .muldiv_busy(muldiv_busy), .syscall_pending(syscall_pending),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
        .ex_reg_dest(ex_reg_dest), .ex_branch_variant(ex_branch_variant),
        .ex_muldiv_op(ex_muldiv_op), .ex_hilo_rd(ex_hilo_rd)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [5:0] op, input logic [5:0] fn,
                                  input logic [4:0] rt, input logic valid,
                                  input logic stall, input logic fl,
                                  input logic done);
        opcode       = op;
        funct        = fn;
        reg_rt_id    = rt;
        id_valid     = valid;
        ex_stall     = stall;
        flush        = fl;
        syscall_done = done;
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Directed sequence of steps with hand-computed expectations
    initial begin
        reset = 1'b1;
        apply_stimulus(6'h00, 6'h00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check_output("rst_ex_valid", 32'(ex_valid), 32'd0);
        check_output("rst_reg_write", 32'(ex_reg_write), 32'd0);
        check_output("rst_busy", 32'(muldiv_busy), 32'd0);
        check_output("rst_pending", 32'(syscall_pending), 32'd0);
        check_output("rst_bv", 32'(ex_branch_variant), 32'(BV_NONE));
        reset = 1'b0;

        // Loads, stores and ALU forms
        apply_stimulus(6'h23, 6'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_output("lw_no_stall", 32'(id_stall), 32'd0);
        tick();
        check_output("lw_valid", 32'(ex_valid), 32'd1);
        check_output("lw_reg_write", 32'(ex_reg_write), 32'd1);
        check_output("lw_mem_to_reg", 32'(ex_mem_to_reg), 32'd1);
        check_output("lw_alu_src", 32'(ex_alu_src), 32'd1);
        check_output("lw_mem_write", 32'(ex_mem_write), 32'd0);
        check_output("lw_alu_op", 32'(ex_alu_op), 32'(ALU_ADD));
        apply_stimulus(6'h2b, 6'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_output("sw_mem_write", 32'(ex_mem_write), 32'd1);
        check_output("sw_reg_write", 32'(ex_reg_write), 32'd0);
        check_output("sw_mem_to_reg", 32'(ex_mem_to_reg), 32'd0);
        apply_stimulus(6'h00, 6'h25, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_output("or_reg_dest", 32'(ex_reg_dest), 32'd1);
        check_output("or_alu_src", 32'(ex_alu_src), 32'd0);
        check_output("or_alu_op", 32'(ex_alu_op), 32'(ALU_OR));
        apply_stimulus(6'h0d, 6'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_output("ori_reg_dest", 32'(ex_reg_dest), 32'd0);
        check_output("ori_reg_write", 32'(ex_reg_write), 32'd1);
        apply_stimulus(6'h23, 6'h00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_output("invalid_bubble", 32'(ex_valid), 32'd0);
        check_output("invalid_reg_write", 32'(ex_reg_write), 32'd0);

        // MULT followed by MFHI: four stall cycles with bubbles
        apply_stimulus(6'h00, 6'h18, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_output("mult_op", 32'(ex_muldiv_op), 32'd1);
        check_output("mult_reg_write", 32'(ex_reg_write), 32'd0);
        check_output("mult_busy", 32'(muldiv_busy), 32'd1);
        apply_stimulus(6'h00, 6'h10, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check_output($sformatf("mfhi_stall_%0d", i), 32'(id_stall), 32'd1);
            tick();
            check_output($sformatf("mfhi_bubble_%0d", i), 32'(ex_valid), 32'd0);
        end
        check_output("mfhi_stall_done", 32'(id_stall), 32'd0);
        check_output("mult_not_busy", 32'(muldiv_busy), 32'd0);
        tick();
        check_output("mfhi_valid", 32'(ex_valid), 32'd1);
        check_output("mfhi_hilo", 32'(ex_hilo_rd), 32'd2);
        check_output("mfhi_reg_write", 32'(ex_reg_write), 32'd1);

        // DIV followed by MFLO: thirty-two stall cycles
        apply_stimulus(6'h00, 6'h1a, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_output("div_op", 32'(ex_muldiv_op), 32'd2);
        apply_stimulus(6'h00, 6'h12, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        stall_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (!id_stall) break;
            stall_cycles++;
            tick();
        end
        check_output("div_stall_cycles", 32'(stall_cycles), 32'd32);
        tick();
        check_output("mflo_hilo", 32'(ex_hilo_rd), 32'd1);

        // Syscall handshake, including a stray ack while idle
        apply_stimulus(6'h00, 6'h00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_output("stray_done", 32'(syscall_pending), 32'd0);
        apply_stimulus(6'h00, 6'h0c, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_output("sys_pending", 32'(syscall_pending), 32'd1);
        check_output("sys_valid", 32'(ex_valid), 32'd1);
        check_output("sys_reg_write", 32'(ex_reg_write), 32'd0);
        apply_stimulus(6'h09, 6'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_output("sys_stall_a", 32'(id_stall), 32'd1);
        tick();
        tick();
        check_output("sys_stall_b", 32'(id_stall), 32'd1);
        check_output("sys_bubble", 32'(ex_valid), 32'd0);
        apply_stimulus(6'h09, 6'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        check_output("sys_stall_ack", 32'(id_stall), 32'd1);
        tick();
        apply_stimulus(6'h09, 6'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_output("sys_released", 32'(syscall_pending), 32'd0);
        check_output("sys_stall_clear", 32'(id_stall), 32'd0);
        check_output("sys_last_bubble", 32'(ex_valid), 32'd0);
        tick();
        check_output("addiu_valid", 32'(ex_valid), 32'd1);
        check_output("addiu_alu_src", 32'(ex_alu_src), 32'd1);

        // Branch variants, flush and ex_stall hold
        apply_stimulus(6'h05, 6'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_output("bne_bv", 32'(ex_branch_variant), 32'(BV_BNE));
        check_output("bne_alu_op", 32'(ex_alu_op), 32'(ALU_SUB));
        apply_stimulus(6'h04, 6'h00, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check_output("hold_bv", 32'(ex_branch_variant), 32'(BV_BNE));
        check_output("hold_valid", 32'(ex_valid), 32'd1);
        apply_stimulus(6'h04, 6'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_output("beq_bv", 32'(ex_branch_variant), 32'(BV_BEQ));
        apply_stimulus(6'h04, 6'h00, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check_output("flush_valid", 32'(ex_valid), 32'd0);
        check_output("flush_bv", 32'(ex_branch_variant), 32'(BV_NONE));
        apply_stimulus(6'h02, 6'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_output("j_bv", 32'(ex_branch_variant), 32'(BV_JUMP));
        apply_stimulus(6'h00, 6'h08, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_output("jr_bv", 32'(ex_branch_variant), 32'(BV_JUMP_REG));
        check_output("jr_reg_write", 32'(ex_reg_write), 32'd0);
        apply_stimulus(6'h01, 6'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_output("bltz_bv", 32'(ex_branch_variant), 32'(BV_BLTZ));
        apply_stimulus(6'h00, 6'h0c, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check_output("sys_flush_pending", 32'(syscall_pending), 32'd0);
        apply_stimulus(6'h00, 6'h0c, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check_output("sys_exstall_pending", 32'(syscall_pending), 32'd0);
        apply_stimulus(6'h00, 6'h0c, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_output("sys_late_pending", 32'(syscall_pending), 32'd1);
        apply_stimulus(6'h00, 6'h00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_output("sys_late_release", 32'(syscall_pending), 32'd0);

        // Reset while DIV is busy (count 17) and the FSM waits
        apply_stimulus(6'h00, 6'h1a, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        apply_stimulus(6'h00, 6'h0c, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        apply_stimulus(6'h0d, 6'h00, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) tick();
        check_output("pre_rst_busy", 32'(muldiv_busy), 32'd1);
        check_output("pre_rst_pending", 32'(syscall_pending), 32'd1);
        check_output("pre_rst_valid", 32'(ex_valid), 32'd1);
        check_output("pre_rst_stall", 32'(id_stall), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check_output("post_rst_busy", 32'(muldiv_busy), 32'd0);
        check_output("post_rst_pending", 32'(syscall_pending), 32'd0);
        check_output("post_rst_valid", 32'(ex_valid), 32'd0);
        check_output("post_rst_reg_dest", 32'(ex_reg_dest), 32'd0);
        check_output("post_rst_stall", 32'(id_stall), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
